frame_buffer_scanout: RTL



---
 rtl/frame_buffer_scanout_pkg.sv | 24 ++
 rtl/frame_buffer_scanout_timing.sv | 68 ++++++
 rtl/frame_buffer_scanout.sv | 112 +++++++++++
 3 files changed

// File: rtl/frame_buffer_scanout_pkg.sv
// Shared 640x480@60 timing constants and frame-buffer sizing helpers for the
// renderer and the scanout block.
package frame_buffer_scanout_pkg;

    localparam int HOR_ACTIVE_640 = 640;
    localparam int HOR_FP_640     = 16;
    localparam int HOR_SYNC_640   = 96;
    localparam int HOR_BP_640     = 48;
    localparam int VER_ACTIVE_480 = 480;
    localparam int VER_FP_480     = 10;
    localparam int VER_SYNC_480   = 2;
    localparam int VER_BP_480     = 33;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int fb_depth(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

    localparam int FB_ADDR_W = $clog2(fb_depth(HOR_ACTIVE_640, VER_ACTIVE_480));

endpackage

// File: rtl/frame_buffer_scanout_timing.sv
// Raster counters for the scanout: stage-0 active/sync decode plus the
// registered frame_start strobe that marks the first blanking line.
module vga_timing
    import frame_buffer_scanout_pkg::*;
#(
    parameter int HA  = HOR_ACTIVE_640,
    parameter int HFP = HOR_FP_640,
    parameter int HS  = HOR_SYNC_640,
    parameter int HBP = HOR_BP_640,
    parameter int VA  = VER_ACTIVE_480,
    parameter int VFP = VER_FP_480,
    parameter int VS  = VER_SYNC_480,
    parameter int VBP = VER_BP_480,
    localparam int H_W = $clog2(line_total(HA, HFP, HS, HBP)),
    localparam int V_W = $clog2(line_total(VA, VFP, VS, VBP))
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           active,
    output logic           hs_n,
    output logic           vs_n,
    output logic           frame_start
);

    localparam logic [H_W-1:0] H_LAST  = H_W'(line_total(HA, HFP, HS, HBP) - 1);
    localparam logic [V_W-1:0] V_LAST  = V_W'(line_total(VA, VFP, VS, VBP) - 1);
    localparam logic [H_W-1:0] H_ACT   = H_W'(HA);
    localparam logic [V_W-1:0] V_ACT   = V_W'(VA);
    localparam logic [H_W-1:0] HS_BEG  = H_W'(HA + HFP);
    localparam logic [H_W-1:0] HS_END  = H_W'(HA + HFP + HS);
    localparam logic [V_W-1:0] VS_BEG  = V_W'(VA + VFP);
    localparam logic [V_W-1:0] VS_END  = V_W'(VA + VFP + VS);

    logic [H_W-1:0] h_cnt, h_next;
    logic [V_W-1:0] v_cnt, v_next;

    always_comb begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // frame_start is decoded from the next count so it is high exactly while
    // the counters sit at (0, VA), with no decode logic on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            frame_start <= (h_next == '0) && (v_next == V_ACT);
        end
    end

    assign x      = h_cnt;
    assign y      = v_cnt;
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

endmodule

// File: rtl/frame_buffer_scanout.sv
// Double-buffered 1-bpp frame store: renderer writes land in the back buffer,
// the front buffer is scanned out with 2-cycle aligned pixel/sync latency.
module frame_buffer_scanout
    import frame_buffer_scanout_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = HOR_ACTIVE_640,
    parameter int VER_ACTIVE_PIXELS = VER_ACTIVE_480,
    parameter int HOR_FRONT_PORCH   = HOR_FP_640,
    parameter int HOR_SYNC          = HOR_SYNC_640,
    parameter int HOR_BACK_PORCH    = HOR_BP_640,
    parameter int VER_FRONT_PORCH   = VER_FP_480,
    parameter int VER_SYNC          = VER_SYNC_480,
    parameter int VER_BACK_PORCH    = VER_BP_480,
    parameter int ADDR_W            = $clog2(fb_depth(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              swap,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              pixel
);

    localparam int DEPTH = fb_depth(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int MEM_W = $clog2(DEPTH);
    localparam int H_W   = $clog2(line_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC, HOR_BACK_PORCH));
    localparam int V_W   = $clog2(line_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC, VER_BACK_PORCH));

    logic [H_W-1:0]   x;
    logic [V_W-1:0]   y;
    logic             active, hs_n, vs_n, frame_start;
    logic             front_sel;
    logic [MEM_W-1:0] rd_addr, wr_idx;
    logic             wr_ok;
    logic             rd_q;
    logic             active_d, hs_d, vs_d;

    logic buf0 [DEPTH];
    logic buf1 [DEPTH];

    vga_timing #(
        .HA  (HOR_ACTIVE_PIXELS),
        .HFP (HOR_FRONT_PORCH),
        .HS  (HOR_SYNC),
        .HBP (HOR_BACK_PORCH),
        .VA  (VER_ACTIVE_PIXELS),
        .VFP (VER_FRONT_PORCH),
        .VS  (VER_SYNC),
        .VBP (VER_BACK_PORCH)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .active      (active),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .frame_start (frame_start)
    );

    // Out-of-range addresses are dropped rather than truncated into the array.
    assign wr_ok   = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign wr_idx  = MEM_W'(wr_addr);
    assign rd_addr = active ? MEM_W'(int'(y) * HOR_ACTIVE_PIXELS + int'(x)) : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (front_sel) begin
                buf0[wr_idx] <= wr_data;
            end else begin
                buf1[wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= front_sel ? buf1[rd_addr] : buf0[rd_addr];
    end

    // A write in the frame_start cycle still sees the old front_sel, so it
    // lands in the buffer that becomes the new front.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
            active_d  <= 1'b0;
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            pixel     <= 1'b0;
        end else begin
            if (frame_start) begin
                front_sel <= ~front_sel;
            end
            active_d <= active;
            hs_d     <= hs_n;
            vs_d     <= vs_n;
            de       <= active_d;
            hsync    <= hs_d;
            vsync    <= vs_d;
            pixel    <= active_d & rd_q;
        end
    end

    assign swap = frame_start;

endmodule
